ldm_wb_seq: RTL and testbench

LDM_WB_SEQ -- requirements
Module: ldm_wb_seq

---
 rtl/arm_pkg.sv | 25 ++
 rtl/ldm_wb_seq_if.sv | 23 ++
 rtl/lowest_set16.sv | 19 +
 rtl/ldm_wb_seq.sv | 147 ++++++++++++++
 tb/tb_ldm_wb_seq.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/arm_pkg.sv
// Shared types and constants for the load-multiple sequencer.
package arm_pkg;

   localparam int unsigned WORD_BYTES = 4;
   localparam logic [3:0]  PC_IDX     = 4'hF;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WRITE,
      WB,
      DONE
   } ldm_state_t;

   // Number of registers named in a 16-bit register list.
   function automatic logic [4:0] popcount(input logic [15:0] v);
      logic [4:0] cnt;
      cnt = '0;
      for (int i = 0; i < 16; i++) begin
         cnt = cnt + {4'd0, v[i]};
      end
      return cnt;
   endfunction

endpackage

// File: rtl/ldm_wb_seq_if.sv
// Word-read memory bus: request held until a one-cycle read response.
interface ldm_wb_seq_if #(
   parameter int unsigned ADDR_W = 32
);
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rvalid;
   logic [ADDR_W-1:0] mem_rdata;

   modport master (
      output mem_req,
      output mem_addr,
      input  mem_rvalid,
      input  mem_rdata
   );

   modport slave (
      input  mem_req,
      input  mem_addr,
      output mem_rvalid,
      output mem_rdata
   );
endinterface

// File: rtl/lowest_set16.sv
// Priority encoder: index of the lowest set bit of a 16-bit vector.
module lowest_set16 (
   input  logic [15:0] vec,
   output logic [3:0]  idx,
   output logic        valid
);

   // Scan from the top down so the lowest set bit is the last one to win.
   always_comb begin
      idx   = '0;
      valid = |vec;
      for (int i = 15; i >= 0; i--) begin
         if (vec[i]) begin
            idx = 4'(i);
         end
      end
   end

endmodule

// File: rtl/ldm_wb_seq.sv
// LDM sequencer: reads one word per listed register in ascending order,
// writes each into the register file (R15 goes to the PC), then optionally
// writes back the updated base register.
module ldm_wb_seq
   import arm_pkg::*;
#(
   parameter int unsigned ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [15:0]       reglist,
   input  logic [ADDR_W-1:0] base,
   input  logic [3:0]        rn,
   input  logic              up,
   input  logic              pre,
   input  logic              wb,
   ldm_wb_seq_if.master      mem,
   output logic              we3,
   output logic [3:0]        wa3,
   output logic [ADDR_W-1:0] wd3,
   output logic              pc_we,
   output logic [ADDR_W-1:0] pc_wd,
   output logic              busy,
   output logic              done
);

   ldm_state_t        state_q;
   logic [15:0]       list_q;
   logic [3:0]        rn_q;
   logic              wb_en_q;
   logic [ADDR_W-1:0] wb_val_q;

   logic [15:0]       scan_in;
   logic [3:0]        scan_idx;
   logic              scan_valid;
   logic [15:0]       list_rest;
   logic [ADDR_W-1:0] span;
   logic [ADDR_W-1:0] start_addr;

   // In IDLE the encoder looks at the incoming list to detect an empty
   // request; otherwise it picks the next register still to be loaded.
   assign scan_in   = (state_q == IDLE) ? reglist : list_q;
   assign list_rest = list_q & (list_q - 16'd1);

   lowest_set16 u_lowest (
      .vec   (scan_in),
      .idx   (scan_idx),
      .valid (scan_valid)
   );

   // Lowest transfer address and total span of the block.
   always_comb begin
      span = ADDR_W'(popcount(reglist)) * ADDR_W'(WORD_BYTES);
      case ({up, pre})
         2'b11:   start_addr = base + ADDR_W'(WORD_BYTES);
         2'b10:   start_addr = base;
         2'b01:   start_addr = base - span;
         default: start_addr = base - span + ADDR_W'(WORD_BYTES);
      endcase
   end

   // Sequencer FSM; every output is a register set on entry to its state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         list_q       <= '0;
         rn_q         <= '0;
         wb_en_q      <= 1'b0;
         wb_val_q     <= '0;
         mem.mem_req  <= 1'b0;
         mem.mem_addr <= '0;
         we3          <= 1'b0;
         wa3          <= '0;
         wd3          <= '0;
         pc_we        <= 1'b0;
         pc_wd        <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  busy <= 1'b1;
                  if (scan_valid) begin
                     list_q       <= reglist;
                     rn_q         <= rn;
                     // A loaded base register must not be overwritten by writeback.
                     wb_en_q      <= wb & ~reglist[rn];
                     wb_val_q     <= up ? base + span : base - span;
                     mem.mem_addr <= start_addr;
                     mem.mem_req  <= 1'b1;
                     state_q      <= REQ;
                  end else begin
                     done    <= 1'b1;
                     state_q <= DONE;
                  end
               end
            end
            REQ: begin
               if (mem.mem_rvalid) begin
                  mem.mem_req <= 1'b0;
                  state_q     <= WRITE;
                  if (scan_idx == PC_IDX) begin
                     pc_we <= 1'b1;
                     pc_wd <= mem.mem_rdata;
                  end else begin
                     we3 <= 1'b1;
                     wa3 <= scan_idx;
                     wd3 <= mem.mem_rdata;
                  end
               end
            end
            WRITE: begin
               we3          <= 1'b0;
               pc_we        <= 1'b0;
               list_q       <= list_rest;
               mem.mem_addr <= mem.mem_addr + ADDR_W'(WORD_BYTES);
               if (|list_rest) begin
                  mem.mem_req <= 1'b1;
                  state_q     <= REQ;
               end else if (wb_en_q) begin
                  we3     <= 1'b1;
                  wa3     <= rn_q;
                  wd3     <= wb_val_q;
                  state_q <= WB;
               end else begin
                  done    <= 1'b1;
                  state_q <= DONE;
               end
            end
            WB: begin
               we3     <= 1'b0;
               done    <= 1'b1;
               state_q <= DONE;
            end
            DONE: begin
               done    <= 1'b0;
               busy    <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ldm_wb_seq.sv
// Self-checking bench for ldm_wb_seq: directed scenarios plus randomized
// transfers scored against a transaction-level model of the LDM rules.
module tb_ldm_wb_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [15:0] reglist;
   logic [31:0] base;
   logic [3:0]  rn;
   logic        up, pre, wb;
   logic        we3, pc_we, busy, done;
   logic [3:0]  wa3;
   logic [31:0] wd3, pc_wd;

   ldm_wb_seq_if #(.ADDR_W(32)) bus ();

   ldm_wb_seq #(.ADDR_W(32)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .reglist (reglist),
      .base    (base),
      .rn      (rn),
      .up      (up),
      .pre     (pre),
      .wb      (wb),
      .mem     (bus),
      .we3     (we3),
      .wa3     (wa3),
      .wd3     (wd3),
      .pc_we   (pc_we),
      .pc_wd   (pc_wd),
      .busy    (busy),
      .done    (done)
   );

   always #5 clk = ~clk;

   int vec = 0;
   int miss = 0;

   // Memory responder controls: lat = cycles from request to response (0 = silent).
   int lat = 1;
   bit inject = 1'b0;
   int rsp_cnt = 0;

   // Observation logs: reads {5'b0, addr}; writes {is_pc, idx, data}.
   logic [36:0] rd_log[$];
   logic [36:0] wr_log[$];
   logic [36:0] exp_rd[$];
   logic [36:0] exp_wr[$];

   int   cyc = 0;
   int   done_cnt = 0, done_cyc = 0, last_wr_cyc = 0;
   int   both_cnt = 0, we15_cnt = 0, req_rise = 0, req_hi = 0, busy_cnt = 0;
   logic req_prev = 1'b0;

   int rd0, wr0, dn0, rq0, rh0, bz0, start_cyc;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Memory model: answers a held request after lat cycles.
   always @(negedge clk) begin
      bus.mem_rvalid <= 1'b0;
      if (!rst_n) begin
         rsp_cnt <= 0;
      end else if (inject) begin
         bus.mem_rvalid <= 1'b1;
         bus.mem_rdata  <= 32'hDEAD_BEEF;
      end else if (bus.mem_req && lat != 0) begin
         if (rsp_cnt + 1 >= lat) begin
            bus.mem_rvalid <= 1'b1;
            bus.mem_rdata  <= mem_word(bus.mem_addr);
            rd_log.push_back({5'b0, bus.mem_addr});
            rsp_cnt <= 0;
         end else begin
            rsp_cnt <= rsp_cnt + 1;
         end
      end else begin
         rsp_cnt <= 0;
      end
   end

   // Output monitor.
   always @(negedge clk) begin
      if (we3)   wr_log.push_back({1'b0, wa3, wd3});
      if (pc_we) wr_log.push_back({1'b1, 4'hF, pc_wd});
      if (we3 || pc_we) last_wr_cyc <= cyc;
      if (we3 && pc_we) both_cnt <= both_cnt + 1;
      if (we3 && wa3 == 4'hF) we15_cnt <= we15_cnt + 1;
      if (done) begin
         done_cnt <= done_cnt + 1;
         done_cyc <= cyc;
      end
      if (bus.mem_req) req_hi <= req_hi + 1;
      if (bus.mem_req && !req_prev) req_rise <= req_rise + 1;
      req_prev <= bus.mem_req;
      if (busy) busy_cnt <= busy_cnt + 1;
   end

   // Reference model: the ordered reads and register-file writes an LDM implies.
   task automatic build_model(input logic [15:0] rl, input logic [31:0] b, input logic [3:0] r,
                              input bit u, input bit p, input bit w);
      int n;
      logic [31:0] a;
      n = $countones(rl);
      exp_rd.delete();
      exp_wr.delete();
      if (rl == 16'h0) return;
      a = u ? (p ? b + 32'd4 : b) : (p ? b - 32'(4 * n) : b - 32'(4 * n) + 32'd4);
      for (int i = 0; i < 16; i++) begin
         if (rl[i]) begin
            exp_rd.push_back({5'b0, a});
            exp_wr.push_back({(i == 15), 4'(i), mem_word(a)});
            a = a + 32'd4;
         end
      end
      if (w && !rl[r]) exp_wr.push_back({1'b0, r, u ? b + 32'(4 * n) : b - 32'(4 * n)});
   endtask

   function automatic int first_diff(input logic [36:0] got[$], input int from,
                                     input logic [36:0] exp[$]);
      int ng;
      ng = got.size() - from;
      for (int i = 0; i < exp.size() && i < ng; i++) begin
         if (got[from + i] !== exp[i]) return i;
      end
      if (ng != exp.size()) return (ng < exp.size()) ? ng : exp.size();
      return -1;
   endfunction

   function automatic logic [36:0] pick(input logic [36:0] q[$], input int i);
      if (i < 0 || i >= q.size()) return '1;
      return q[i];
   endfunction

   // Issue one LDM and wait (bounded) for its done pulse.
   task automatic run_seq(input logic [15:0] rl, input logic [31:0] b, input logic [3:0] r,
                          input bit u, input bit p, input bit w, input int lt, input bit mid,
                          output bit ok);
      build_model(rl, b, r, u, p, w);
      lat = lt;
      ok  = 1'b0;
      rd0 = rd_log.size();
      wr0 = wr_log.size();
      dn0 = done_cnt;
      rq0 = req_rise;
      rh0 = req_hi;
      bz0 = busy_cnt;
      @(negedge clk);
      reglist = rl; base = b; rn = r; up = u; pre = p; wb = w;
      start = 1'b1;
      start_cyc = cyc;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         start = mid && (i == 4);
         if (mid) begin
            reglist = ~rl;
            base    = ~b;
            up      = ~u;
         end
         #1;
         if (done_cnt != dn0) begin
            ok = 1'b1;
            break;
         end
      end
      start = 1'b0;
      @(negedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      vec++;
      if ({we3, pc_we, busy, done, bus.mem_req} !== 5'b0) begin
         miss++;
         $display("FAIL reset_flags: got %b exp 00000", {we3, pc_we, busy, done, bus.mem_req});
      end
      vec++;
      if (wa3 !== 4'h0 || wd3 !== 32'h0) begin
         miss++;
         $display("FAIL reset_rf: got wa3=%h wd3=%h exp 0/0", wa3, wd3);
      end
      vec++;
      if (pc_wd !== 32'h0 || bus.mem_addr !== 32'h0) begin
         miss++;
         $display("FAIL reset_pc_addr: got pc_wd=%h addr=%h exp 0/0", pc_wd, bus.mem_addr);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_wb_after();
      bit ok;
      int d;
      run_seq(16'h0006, 32'h100, 4'd0, 1'b1, 1'b0, 1'b1, 1, 1'b0, ok);
      vec++;
      if (!ok) begin miss++; $display("FAIL wb_after_done: got timeout exp done"); end
      d = first_diff(rd_log, rd0, exp_rd);
      vec++;
      if (d >= 0) begin
         miss++;
         $display("FAIL wb_after_reads[%0d]: got %h exp %h", d, pick(rd_log, rd0 + d), pick(exp_rd, d));
      end
      d = first_diff(wr_log, wr0, exp_wr);
      vec++;
      if (d >= 0) begin
         miss++;
         $display("FAIL wb_after_writes[%0d]: got %h exp %h", d, pick(wr_log, wr0 + d), pick(exp_wr, d));
      end
      vec++;
      if (pick(wr_log, wr_log.size() - 1) !== {1'b0, 4'd0, 32'h108}) begin
         miss++;
         $display("FAIL wb_after_r0: got %h exp %h", pick(wr_log, wr_log.size() - 1), {1'b0, 4'd0, 32'h108});
      end
      vec++;
      if (done_cyc != last_wr_cyc + 1) begin
         miss++;
         $display("FAIL wb_after_done_cycle: got %0d exp %0d", done_cyc, last_wr_cyc + 1);
      end
      vec++;
      if (busy_cnt == bz0) begin miss++; $display("FAIL wb_after_busy: got 0 busy cycles exp >0"); end
   endtask

   task automatic test_pc_load();
      bit ok;
      int d;
      int b0, w15;
      b0 = both_cnt;
      w15 = we15_cnt;
      run_seq(16'h8001, 32'h200, 4'd3, 1'b0, 1'b1, 1'b0, 2, 1'b0, ok);
      vec++;
      if (!ok) begin miss++; $display("FAIL pc_load_done: got timeout exp done"); end
      vec++;
      if (pick(rd_log, rd0) !== {5'b0, 32'h1F8}) begin
         miss++;
         $display("FAIL pc_load_first_addr: got %h exp 1f8", pick(rd_log, rd0));
      end
      d = first_diff(rd_log, rd0, exp_rd);
      vec++;
      if (d >= 0) begin
         miss++;
         $display("FAIL pc_load_reads[%0d]: got %h exp %h", d, pick(rd_log, rd0 + d), pick(exp_rd, d));
      end
      d = first_diff(wr_log, wr0, exp_wr);
      vec++;
      if (d >= 0) begin
         miss++;
         $display("FAIL pc_load_writes[%0d]: got %h exp %h", d, pick(wr_log, wr0 + d), pick(exp_wr, d));
      end
      vec++;
      if (both_cnt != b0 || we15_cnt != w15) begin
         miss++;
         $display("FAIL pc_load_exclusive: got both=%0d we15=%0d exp 0/0", both_cnt - b0, we15_cnt - w15);
      end
   endtask

   task automatic test_wb_skip();
      bit ok;
      int d;
      run_seq(16'h0010, $urandom, 4'd4, 1'b1, 1'($urandom), 1'b1, 1, 1'b0, ok);
      vec++;
      if (!ok) begin miss++; $display("FAIL wb_skip_done: got timeout exp done"); end
      d = first_diff(wr_log, wr0, exp_wr);
      vec++;
      if (d >= 0 || wr_log.size() - wr0 != 1) begin
         miss++;
         $display("FAIL wb_skip_writes: got n=%0d first %h exp n=1 %h", wr_log.size() - wr0,
                  pick(wr_log, wr0), pick(exp_wr, 0));
      end
   endtask

   task automatic test_empty();
      bit ok;
      run_seq(16'h0000, 32'h300, 4'd2, 1'b1, 1'b0, 1'b1, 1, 1'b0, ok);
      vec++;
      if (!ok || done_cyc != start_cyc + 1) begin
         miss++;
         $display("FAIL empty_done_cycle: got %0d exp %0d", done_cyc, start_cyc + 1);
      end
      vec++;
      if (req_rise != rq0 || wr_log.size() != wr0) begin
         miss++;
         $display("FAIL empty_no_access: got req=%0d wr=%0d exp 0/0", req_rise - rq0, wr_log.size() - wr0);
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      int d;
      run_seq(16'h0421, 32'h8000_0010, 4'd7, 1'b1, 1'b1, 1'b1, 3, 1'b1, ok);
      repeat (10) @(negedge clk);
      #1;
      vec++;
      if (!ok || done_cnt - dn0 != 1) begin
         miss++;
         $display("FAIL b2b_done_count: got %0d exp 1", done_cnt - dn0);
      end
      d = first_diff(wr_log, wr0, exp_wr);
      vec++;
      if (d >= 0) begin
         miss++;
         $display("FAIL b2b_writes[%0d]: got %h exp %h", d, pick(wr_log, wr0 + d), pick(exp_wr, d));
      end
      vec++;
      if (req_hi - rh0 != 9 || req_rise - rq0 != 3) begin
         miss++;
         $display("FAIL b2b_req_hold: got hi=%0d rises=%0d exp 9/3", req_hi - rh0, req_rise - rq0);
      end
   endtask

   task automatic test_random();
      bit ok;
      int d, d2;
      logic [15:0] rl;
      for (int k = 0; k < 25; k++) begin
         rl = 16'($urandom) & 16'($urandom);
         if (k == 5) rl = 16'h0;
         if (k == 9) rl = 16'hFFFF;
         run_seq(rl, $urandom, 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 int'($urandom_range(1, 4)), 1'b0, ok);
         d  = first_diff(rd_log, rd0, exp_rd);
         d2 = first_diff(wr_log, wr0, exp_wr);
         vec++;
         if (!ok || d >= 0 || d2 >= 0 || done_cnt - dn0 != 1) begin
            miss++;
            $display("FAIL random[%0d] list=%h: got rd %h wr %h done=%0d exp rd %h wr %h done=1", k, rl,
                     pick(rd_log, rd0 + d), pick(wr_log, wr0 + d2), done_cnt - dn0,
                     pick(exp_rd, d), pick(exp_wr, d2));
         end
      end
      vec++;
      if (both_cnt != 0) begin miss++; $display("FAIL random_exclusive: got %0d exp 0", both_cnt); end
   endtask

   task automatic test_reset_mid();
      bit ok;
      int w0, d0;
      lat = 3;
      w0 = wr_log.size();
      d0 = done_cnt;
      @(negedge clk);
      reglist = 16'h0124; base = 32'h4000; rn = 4'd0; up = 1'b1; pre = 1'b0; wb = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         #1;
         if (wr_log.size() > w0 && bus.mem_req) begin
            ok = 1'b1;
            break;
         end
      end
      vec++;
      if (!ok) begin miss++; $display("FAIL reset_mid_reach: got timeout exp second REQ"); end
      #1;
      rst_n = 1'b0;
      lat = 0;
      #1;
      vec++;
      if ({bus.mem_req, we3, pc_we, busy, done} !== 5'b0 || wa3 !== 4'h0 || wd3 !== 32'h0 ||
          pc_wd !== 32'h0 || bus.mem_addr !== 32'h0) begin
         miss++;
         $display("FAIL reset_mid_clear: got flags=%b wa3=%h wd3=%h addr=%h exp all 0",
                  {bus.mem_req, we3, pc_we, busy, done}, wa3, wd3, bus.mem_addr);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      inject = 1'b1;
      @(posedge clk);
      inject = 1'b0;
      repeat (6) @(negedge clk);
      #1;
      vec++;
      if (wr_log.size() - w0 != 1 || pick(wr_log, w0) !== {1'b0, 4'd2, mem_word(32'h4000)}) begin
         miss++;
         $display("FAIL reset_mid_writes: got n=%0d first %h exp n=1 %h", wr_log.size() - w0,
                  pick(wr_log, w0), {1'b0, 4'd2, mem_word(32'h4000)});
      end
      vec++;
      if (busy !== 1'b0 || bus.mem_req !== 1'b0 || done_cnt != d0) begin
         miss++;
         $display("FAIL reset_mid_idle: got busy=%b req=%b done=%0d exp 0/0/0", busy, bus.mem_req,
                  done_cnt - d0);
      end
      lat = 1;
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; reglist = '0; base = '0; rn = '0;
      up = 1'b0; pre = 1'b0; wb = 1'b0;
      test_reset();
      test_wb_after();
      test_pc_load();
      test_wb_skip();
      test_empty();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule
